dca_matrix_row_assembler: RTL and testbench

// - Sits directly downstream of the matrix LSU load port. Consumes the

---
 rtl/dca_matrix_row_assembler_pkg.sv | 30 +++
 rtl/dca_matrix_row_assembler_tile_bank.sv | 55 +++++
 rtl/dca_matrix_row_assembler.sv | 106 ++++++++++
 tb/tb_dca_matrix_row_assembler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dca_matrix_row_assembler_pkg.sv
// Shared definitions for the matrix row assembler: bank selection, width helpers
// and tile packing offsets used by both the assembler and the MAC side.
package dca_matrix_row_assembler_pkg;

    localparam int unsigned NUM_BANKS   = 2;
    localparam int unsigned BW_BANK_IDX = 1;

    typedef enum logic [BW_BANK_IDX-1:0] {
        BANK_0 = 1'b0,
        BANK_1 = 1'b1
    } bank_sel_e;

    function automatic int unsigned calc_bw_num_row(input int unsigned matrix_size);
        return $clog2(matrix_size + 1);
    endfunction

    function automatic int unsigned calc_bw_row_idx(input int unsigned matrix_size);
        return (matrix_size > 1) ? $clog2(matrix_size) : 1;
    endfunction

    // Row i of a packed tile lives at [i*bw_row +: bw_row].
    function automatic int unsigned tile_row_lsb(input int unsigned idx, input int unsigned bw_row);
        return idx * bw_row;
    endfunction

    function automatic bank_sel_e other_bank(input bank_sel_e b);
        return (b == BANK_0) ? BANK_1 : BANK_0;
    endfunction

endpackage

// File: rtl/dca_matrix_row_assembler_tile_bank.sv
// One ping-pong tile bank: row storage, row count and full flag, with the
// unused rows masked to zero on the output.
module dca_matrix_row_assembler_tile_bank
    import dca_matrix_row_assembler_pkg::*;
#(
    parameter int unsigned BW_ROW      = 128,
    parameter int unsigned MATRIX_SIZE = 8,
    parameter int unsigned BW_NUM_ROW  = 4,
    parameter int unsigned BW_ROW_IDX  = 3
) (
    input  logic                          clk,
    input  logic                          rstnn,
    input  logic                          clear,
    input  logic                          wr_en,
    input  logic [BW_ROW_IDX-1:0]         wr_idx,
    input  logic [BW_ROW-1:0]             wr_data,
    input  logic                          close,
    input  logic [BW_NUM_ROW-1:0]         close_num_row,
    input  logic                          take,
    output logic                          full,
    output logic [BW_NUM_ROW-1:0]         num_row,
    output logic [MATRIX_SIZE*BW_ROW-1:0] tile
);

    logic [BW_ROW-1:0] rows [MATRIX_SIZE];

    // Row storage carries no reset; stale rows are hidden by the output mask.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            rows[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstnn || clear) begin
            full    <= 1'b0;
            num_row <= '0;
        end else if (close) begin
            full    <= 1'b1;
            num_row <= close_num_row;
        end else if (take) begin
            full    <= 1'b0;
        end
    end

    always_comb begin
        tile = '0;
        for (int unsigned i = 0; i < MATRIX_SIZE; i++) begin
            if (i < 32'(num_row)) begin
                tile[tile_row_lsb(i, BW_ROW) +: BW_ROW] = rows[i];
            end
        end
    end

endmodule

// File: rtl/dca_matrix_row_assembler.sv
// Assembles LSU row beats into ping-pong matrix tiles for the MAC datapath:
// row counter, bank pointers, missing-wlast flag and the output bank mux.
module dca_matrix_row_assembler
    import dca_matrix_row_assembler_pkg::*;
#(
    parameter  int unsigned BW_ROW      = 128,
    parameter  int unsigned MATRIX_SIZE = 8,
    localparam int unsigned BW_NUM_ROW  = calc_bw_num_row(MATRIX_SIZE)
) (
    input  logic                          clk,
    input  logic                          rstnn,
    input  logic                          clear,
    input  logic                          load_tensor_row_wvalid,
    input  logic                          load_tensor_row_wlast,
    input  logic [BW_ROW-1:0]             load_tensor_row_wdata,
    output logic                          load_tensor_row_wready,
    output logic                          matrix_valid,
    input  logic                          matrix_ready,
    output logic [MATRIX_SIZE*BW_ROW-1:0] matrix_data,
    output logic [BW_NUM_ROW-1:0]         matrix_num_row,
    output logic                          busy,
    output logic                          error_missing_last
);

    localparam int unsigned BW_ROW_IDX = calc_bw_row_idx(MATRIX_SIZE);
    localparam logic [BW_NUM_ROW-1:0] LAST_ROW = BW_NUM_ROW'(MATRIX_SIZE - 1);

    bank_sel_e                     wr_bank;
    bank_sel_e                     rd_bank;
    logic [BW_NUM_ROW-1:0]         row_cnt;
    logic [BW_NUM_ROW-1:0]         row_cnt_inc;
    logic                          error_q;

    logic [NUM_BANKS-1:0]          bank_full;
    logic [NUM_BANKS-1:0]          wr_sel;
    logic [NUM_BANKS-1:0]          rd_sel;
    logic [BW_NUM_ROW-1:0]         bank_num_row [NUM_BANKS];
    logic [MATRIX_SIZE*BW_ROW-1:0] bank_tile    [NUM_BANKS];

    logic                          accept;
    logic                          close_tile;
    logic                          take_tile;

    // Handshakes depend only on registered bank state, so a bank freed by a
    // take becomes writable one cycle later and wvalid never reaches matrix_valid.
    always_comb begin
        wr_sel                 = (wr_bank == BANK_1) ? 2'b10 : 2'b01;
        rd_sel                 = (rd_bank == BANK_1) ? 2'b10 : 2'b01;
        row_cnt_inc            = row_cnt + 1'b1;
        load_tensor_row_wready = !(|(bank_full & wr_sel)) && !clear;
        accept                 = load_tensor_row_wvalid && load_tensor_row_wready;
        close_tile             = accept && (load_tensor_row_wlast || (row_cnt == LAST_ROW));
        matrix_valid           = |(bank_full & rd_sel);
        take_tile              = matrix_valid && matrix_ready && !clear;
    end

    always_ff @(posedge clk) begin
        if (!rstnn || clear) begin
            wr_bank <= BANK_0;
            rd_bank <= BANK_0;
            row_cnt <= '0;
            error_q <= 1'b0;
        end else begin
            if (close_tile) begin
                row_cnt <= '0;
                wr_bank <= other_bank(wr_bank);
                if (!load_tensor_row_wlast) begin
                    error_q <= 1'b1;
                end
            end else if (accept) begin
                row_cnt <= row_cnt_inc;
            end
            if (take_tile) begin
                rd_bank <= other_bank(rd_bank);
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        dca_matrix_row_assembler_tile_bank #(
            .BW_ROW      (BW_ROW),
            .MATRIX_SIZE (MATRIX_SIZE),
            .BW_NUM_ROW  (BW_NUM_ROW),
            .BW_ROW_IDX  (BW_ROW_IDX)
        ) u_tile_bank (
            .clk           (clk),
            .rstnn         (rstnn),
            .clear         (clear),
            .wr_en         (accept && wr_sel[b]),
            .wr_idx        (row_cnt[BW_ROW_IDX-1:0]),
            .wr_data       (load_tensor_row_wdata),
            .close         (close_tile && wr_sel[b]),
            .close_num_row (row_cnt_inc),
            .take          (take_tile && rd_sel[b]),
            .full          (bank_full[b]),
            .num_row       (bank_num_row[b]),
            .tile          (bank_tile[b])
        );
    end

    assign matrix_data        = rd_sel[1] ? bank_tile[1] : bank_tile[0];
    assign matrix_num_row     = rd_sel[1] ? bank_num_row[1] : bank_num_row[0];
    assign busy               = (|bank_full) || (row_cnt != '0);
    assign error_missing_last = error_q;

endmodule

// File: tb/tb_dca_matrix_row_assembler.sv
// Directed scoreboard bench for dca_matrix_row_assembler (BW_ROW=32, MATRIX_SIZE=4).
module tb_dca_matrix_row_assembler;

    localparam int unsigned BW_ROW      = 32;
    localparam int unsigned MATRIX_SIZE = 4;
    localparam int unsigned BW_NUM_ROW  = 3;
    localparam int unsigned BW_TILE     = BW_ROW * MATRIX_SIZE;

    typedef struct {
        logic [BW_TILE-1:0]    data;
        logic [BW_NUM_ROW-1:0] num_row;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rstnn = 1'b0;
    logic                  clear = 1'b0;
    logic                  wvalid = 1'b0;
    logic                  wlast = 1'b0;
    logic [BW_ROW-1:0]     wdata = '0;
    logic                  wready;
    logic                  matrix_valid;
    logic                  matrix_ready = 1'b0;
    logic [BW_TILE-1:0]    matrix_data;
    logic [BW_NUM_ROW-1:0] matrix_num_row;
    logic                  busy;
    logic                  error_missing_last;

    exp_t exp_q[$];
    exp_t mon_e;
    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    dca_matrix_row_assembler #(
        .BW_ROW      (BW_ROW),
        .MATRIX_SIZE (MATRIX_SIZE)
    ) dut (
        .clk                    (clk),
        .rstnn                  (rstnn),
        .clear                  (clear),
        .load_tensor_row_wvalid (wvalid),
        .load_tensor_row_wlast  (wlast),
        .load_tensor_row_wdata  (wdata),
        .load_tensor_row_wready (wready),
        .matrix_valid           (matrix_valid),
        .matrix_ready           (matrix_ready),
        .matrix_data            (matrix_data),
        .matrix_num_row         (matrix_num_row),
        .busy                   (busy),
        .error_missing_last     (error_missing_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [BW_TILE-1:0] act, input logic [BW_TILE-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a tile is taken at the next posedge whenever valid && ready here.
    always @(negedge clk) begin
        if (rstnn && !clear && matrix_valid && matrix_ready) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL unexpected_tile: got %h expected none", matrix_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("tile_data", matrix_data, mon_e.data);
                chk("tile_num_row", BW_TILE'(matrix_num_row), BW_TILE'(mon_e.num_row));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [BW_TILE-1:0] d, input logic [BW_NUM_ROW-1:0] n);
        exp_t e;
        e.data    = d;
        e.num_row = n;
        exp_q.push_back(e);
    endtask

    task automatic send_row(input logic [BW_ROW-1:0] d, input logic last);
        int unsigned n;
        wvalid = 1'b1;
        wdata  = d;
        wlast  = last;
        n      = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wready && n < 50);
        if (!wready) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL wready_timeout: got 0 expected 1 for row %h", d);
        end
        tick();
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned n;
        n = 0;
        while ((exp_q.size() != 0 || matrix_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", BW_TILE'(exp_q.size() == 0 && !matrix_valid), 1);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        @(negedge clk);
        chk("rst_valid", matrix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error_missing_last, 0);
        chk("rst_num_row", matrix_num_row, 0);
        chk("rst_data", matrix_data, 0);
        tick();
        rstnn = 1'b1;
        tick();

        // 1: full tile, check latency before releasing it
        send_row(32'h11, 1'b0);
        send_row(32'h22, 1'b0);
        send_row(32'h33, 1'b0);
        @(negedge clk);
        chk("t1_valid_before_close", matrix_valid, 0);
        chk("t1_busy_partial", busy, 1);
        tick();
        send_row(32'h44, 1'b1);
        @(negedge clk);
        chk("t1_valid", matrix_valid, 1);
        chk("t1_num_row", matrix_num_row, 4);
        chk("t1_data", matrix_data, 128'h00000044_00000033_00000022_00000011);
        chk("t1_error", error_missing_last, 0);
        tick();
        push_exp(128'h00000044_00000033_00000022_00000011, 3'd4);
        matrix_ready = 1'b1;
        wait_drain();
        matrix_ready = 1'b0;

        // 2: short tile, rows 2..3 masked
        push_exp(128'h00000000_00000000_000000A2_000000A1, 3'd2);
        matrix_ready = 1'b1;
        send_row(32'hA1, 1'b0);
        send_row(32'hA2, 1'b1);
        wait_drain();
        matrix_ready = 1'b0;

        // 3: backpressure, third tile stalls behind two full banks
        push_exp(128'h00000104_00000103_00000102_00000101, 3'd4);
        push_exp(128'h00000204_00000203_00000202_00000201, 3'd4);
        push_exp(128'h00000304_00000303_00000302_00000301, 3'd4);
        for (int i = 1; i <= 2; i++) begin
            for (int r = 1; r <= 4; r++) begin
                send_row(BW_ROW'(i * 256 + r), r == 4);
            end
        end
        wvalid = 1'b1;
        wdata  = 32'h301;
        wlast  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t3_stall_wready", wready, 0);
            chk("t3_stall_valid", matrix_valid, 1);
            chk("t3_stall_data", matrix_data, 128'h00000104_00000103_00000102_00000101);
        end
        tick();
        matrix_ready = 1'b1;
        send_row(32'h301, 1'b0);
        send_row(32'h302, 1'b0);
        send_row(32'h303, 1'b0);
        send_row(32'h304, 1'b1);
        wait_drain();
        matrix_ready = 1'b0;

        // 4: missing wlast closes at MATRIX_SIZE rows, flag is sticky
        send_row(32'h51, 1'b0);
        send_row(32'h52, 1'b0);
        send_row(32'h53, 1'b0);
        send_row(32'h54, 1'b0);
        @(negedge clk);
        chk("t4_valid", matrix_valid, 1);
        chk("t4_num_row", matrix_num_row, 4);
        chk("t4_error", error_missing_last, 1);
        tick();
        send_row(32'h55, 1'b0);
        send_row(32'h56, 1'b1);
        push_exp(128'h00000054_00000053_00000052_00000051, 3'd4);
        push_exp(128'h00000000_00000000_00000056_00000055, 3'd2);
        matrix_ready = 1'b1;
        wait_drain();
        matrix_ready = 1'b0;
        @(negedge clk);
        chk("t4_error_sticky", error_missing_last, 1);
        tick();

        // 5: take of one bank and close of the other in the same cycle
        push_exp(128'h00000064_00000063_00000062_00000061, 3'd4);
        push_exp(128'h00000074_00000073_00000072_00000071, 3'd4);
        send_row(32'h61, 1'b0);
        send_row(32'h62, 1'b0);
        send_row(32'h63, 1'b0);
        send_row(32'h64, 1'b1);
        send_row(32'h71, 1'b0);
        send_row(32'h72, 1'b0);
        send_row(32'h73, 1'b0);
        matrix_ready = 1'b1;
        send_row(32'h74, 1'b1);
        @(negedge clk);
        chk("t5_valid", matrix_valid, 1);
        chk("t5_num_row", matrix_num_row, 4);
        chk("t5_data", matrix_data, 128'h00000074_00000073_00000072_00000071);
        chk("t5_wready", wready, 1);
        wait_drain();
        matrix_ready = 1'b0;

        // 6: clear mid-tile, then with both banks full
        send_row(32'h81, 1'b0);
        send_row(32'h82, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        chk("t6a_valid", matrix_valid, 0);
        chk("t6a_busy", busy, 0);
        chk("t6a_error", error_missing_last, 0);
        tick();
        for (int i = 8; i <= 9; i++) begin
            for (int r = 1; r <= 4; r++) begin
                send_row(BW_ROW'(i * 16 + r), r == 4);
            end
        end
        @(negedge clk);
        chk("t6b_full_wready", wready, 0);
        chk("t6b_full_valid", matrix_valid, 1);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        chk("t6b_valid", matrix_valid, 0);
        chk("t6b_busy", busy, 0);
        chk("t6b_error", error_missing_last, 0);
        chk("t6b_wready", wready, 1);
        chk("t6b_data", matrix_data, 0);
        tick();
        send_row(32'hC1, 1'b0);
        send_row(32'hC2, 1'b0);
        send_row(32'hC3, 1'b0);
        send_row(32'hC4, 1'b1);
        @(negedge clk);
        chk("t6c_valid", matrix_valid, 1);
        chk("t6c_num_row", matrix_num_row, 4);
        chk("t6c_data", matrix_data, 128'h000000C4_000000C3_000000C2_000000C1);
        tick();
        push_exp(128'h000000C4_000000C3_000000C2_000000C1, 3'd4);
        matrix_ready = 1'b1;
        wait_drain();
        matrix_ready = 1'b0;

        chk("queue_empty", BW_TILE'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
